// File: rtl/ptw_ctrl.sv
// Page-table-walk controller: round-robin ITLB/DTLB miss arbitration, one PTE read per walk, TLB refill or fault report.
// Latency: miss to mem_req_o 1 cycle, rvalid to refill/done 1 cycle; mem_req_o/mem_addr_o held until mem_gnt_i.
module ptw_ctrl #(
  parameter int VPN_WIDTH  = 20,
  parameter int PPN_WIDTH  = 20,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] ptbr_i,
  input  logic                  itlb_miss_i,
  input  logic [VPN_WIDTH-1:0]  itlb_vpn_i,
  input  logic                  dtlb_miss_i,
  input  logic [VPN_WIDTH-1:0]  dtlb_vpn_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  itlb_wr_en_o,
  output logic                  dtlb_wr_en_o,
  output logic [VPN_WIDTH-1:0]  tlb_vpn_o,
  output logic [PPN_WIDTH-1:0]  tlb_ppn_o,
  output logic                  itlb_done_o,
  output logic                  dtlb_done_o,
  output logic                  fault_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, DRAIN} state_t;

  state_t                  state;
  logic                    prio;      // 0: ITLB wins a tie, 1: DTLB wins a tie
  logic                    owner;     // 0: ITLB, 1: DTLB
  logic [VPN_WIDTH-1:0]    vpn_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    req_q;
  logic                    wr_q;
  logic                    idone_q;
  logic                    ddone_q;
  logic                    fault_q;
  logic [VPN_WIDTH-1:0]    fill_vpn_q;
  logic [PPN_WIDTH-1:0]    fill_ppn_q;

  logic                    grant;
  logic [VPN_WIDTH-1:0]    sel_vpn;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    unused_pte;

  assign grant      = (itlb_miss_i && dtlb_miss_i) ? prio : dtlb_miss_i;
  assign sel_vpn    = grant ? dtlb_vpn_i : itlb_vpn_i;
  assign sel_addr   = ptbr_i + ADDR_WIDTH'({sel_vpn, 2'b00});
  assign unused_pte = ^mem_rdata_i[11:1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      vpn_q      <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      idone_q    <= 1'b0;
      ddone_q    <= 1'b0;
      fault_q    <= 1'b0;
      fill_vpn_q <= '0;
      fill_ppn_q <= '0;
    end else begin
      // refill/done outputs are single-cycle pulses
      wr_q       <= 1'b0;
      idone_q    <= 1'b0;
      ddone_q    <= 1'b0;
      fault_q    <= 1'b0;
      fill_vpn_q <= '0;
      fill_ppn_q <= '0;
      case (state)
        IDLE: begin
          if ((itlb_miss_i || dtlb_miss_i) && !flush_i) begin
            owner  <= grant;
            prio   <= ~grant;
            vpn_q  <= sel_vpn;
            addr_q <= sel_addr;
            req_q  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            req_q <= 1'b0;
            state <= flush_i ? DRAIN : WAIT;
          end else if (flush_i) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (flush_i) begin
              state <= IDLE;
            end else begin
              state   <= FILL;
              idone_q <= ~owner;
              ddone_q <= owner;
              fault_q <= ~mem_rdata_i[0];
              wr_q    <= mem_rdata_i[0];
              if (mem_rdata_i[0]) begin
                fill_vpn_q <= vpn_q;
                fill_ppn_q <= mem_rdata_i[12 +: PPN_WIDTH];
              end
            end
          end else if (flush_i) begin
            state <= DRAIN;
          end
        end
        FILL:    state <= IDLE;
        DRAIN:   if (mem_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in the fill cycle still reports done but must not write the TLB.
  logic wr_ok;
  assign wr_ok        = wr_q && !flush_i;
  assign itlb_wr_en_o = wr_ok && !owner;
  assign dtlb_wr_en_o = wr_ok && owner;
  assign tlb_vpn_o    = wr_ok ? fill_vpn_q : '0;
  assign tlb_ppn_o    = wr_ok ? fill_ppn_q : '0;
  assign itlb_done_o  = idone_q;
  assign dtlb_done_o  = ddone_q;
  assign fault_o      = fault_q;
  assign mem_req_o    = req_q;
  assign mem_addr_o   = req_q ? addr_q : '0;
  assign busy_o       = (state != IDLE);

endmodule
